sipo_frame_rx: RTL and testbench
================================

# sipo_frame_rx

Serial-to-parallel frame receiver. It is the receive end of the serial link driven by our universal shift register's `sout` output. The block collects `N` serial bits per word, MSB-first or LSB-first to match the transmitter's left-shift or right-shift mode. Each completed word goes into a double-buffered output register with a valid/ready handshake and a sticky overrun flag. It sits between a serial source and any parallel consumer (FIFO, register file, bus bridge).

## Interface
Parameters:
- `N`, default 4: word width in bits; legal values `N >= 2`.
- `CW`, default `$clog2(N)`: width of the bit counter.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `shift_en`, input, 1: bit strobe; `sin` is sampled on every rising edge where this is 1.
- `sin`, input, 1: serial data in.
- `msb_first`, input, 1: bit order. 1 means first bit lands in `pout[N-1]`; 0 means first bit lands in `pout[0]`.
- `pout`, output, `N`: received word (holding register).
- `pout_valid`, output, 1: `pout` holds an unconsumed word.
- `pout_ready`, input, 1: consumer accepts `pout` on any edge where `pout_valid && pout_ready`.
- `overrun`, output, 1: sticky flag; a completed word was dropped.
- `clr_ovr`, input, 1: synchronous clear of `overrun`.
- `busy`, output, 1: a word is partially received.
- `bit_cnt`, output, `CW`: number of bits received in the current word.

## Operation
- Reset (while `rst_n` = 0, immediate): shift register = 0, `bit_cnt` = 0, order latch = 1 (MSB-first), state = IDLE, `pout` = 0, `pout_valid` = 0, `overrun` = 0, `busy` = 0.
- FSM states:
  - IDLE (`bit_cnt` = 0, `busy` = 0). Enter RECV on an edge with `shift_en` = 1.
  - RECV (`busy` = 1). Return to IDLE on the edge that samples bit `N`.
- Order latch: `msb_first` is captured on the first bit of each word (IDLE with `shift_en`). It is held for the rest of the word; changes mid-word are ignored.
- Shift rules:
  - MSB-first: `sr <= {sr[N-2:0], sin}`.
  - LSB-first: `sr <= {sin, sr[N-1:1]}`.
- Each sampled bit increments `bit_cnt`. On bit `N`, `bit_cnt` wraps to 0 and the word completes; there is no extra idle cycle. A bit on the next edge starts a new word.
- Word completion. The completed word is `sr` including bit `N`. On the completing edge:
  - If `pout_valid` = 0, or `pout_ready` = 1 on that same edge: `pout` <= word and `pout_valid` <= 1.
  - Otherwise: the word is discarded, `pout` is unchanged, and `overrun` <= 1.
- Handshake: `pout_valid` clears on an edge with `pout_valid && pout_ready` and no completion. `pout` holds its value while valid and not accepted.
- `overrun` clears on an edge with `clr_ovr` = 1. If an overrun event occurs on the same edge, set wins.
- `shift_en` = 0 freezes the shift register, `bit_cnt` and the FSM. Gaps between bits of arbitrary length are legal.

## Timing
- Bit `k` is sampled at the rising edge where `shift_en` = 1. `bit_cnt` reflects it after that edge.
- Latency: `pout_valid` rises after the same edge that samples bit `N`. With contiguous strobes starting at edge `t`, valid is visible from edge `t+N-1` onward.
- Sustained throughput: one word per `N` strobes with `pout_ready` held at 1. No bubble cycles.
- Holding register: one word of buffering beyond the shift register. Reception continues while `pout` is waiting.
- Reset mid-word: the partial word is lost and any held `pout` is cleared. The first strobe after `rst_n` rises starts a new word.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use `N` = 4.
1. Reset: assert `rst_n` = 0 mid-stream, with 2 bits received and `pout_valid` = 1. Required: `pout` = 0, `pout_valid` = 0, `overrun` = 0, `busy` = 0, `bit_cnt` = 0 immediately, without waiting for a clock edge.
2. MSB-first, `pout_ready` = 1: contiguous bits 1,0,1,1. Required: `pout` = 4'b1011, `pout_valid` high for exactly one cycle after the 4th edge, `busy` high during bits 1–3.
3. LSB-first: bits 1,0,1,1 with `shift_en` gaps of 0, 3 and 1 cycles. Required: `pout` = 4'b1101, and `bit_cnt` steps 1, 2, 3, 0 only on strobe edges. Also toggle `msb_first` after bit 2: result is unchanged.
4. Overrun: `pout_ready` = 0; send 4'hA, then 4'h5 (both MSB-first, back-to-back). Required: `pout` stays 4'hA, `overrun` = 1. Pulse `clr_ovr`: `overrun` = 0 and `pout` is still 4'hA.
5. Simultaneous accept and complete: `pout` = 4'h3 valid; assert `pout_ready` on the edge completing 4'hC. Required: `pout` = 4'hC, `pout_valid` stays 1, `overrun` stays 0.
6. Throughput: send 8 contiguous words 4'h0..4'h7 with `pout_ready` = 1. Required: 8 valid beats in order, one every 4 cycles, with no overrun.

Source files
------------

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-to-parallel word receiver with double-buffered, handshaked output
module sipo_frame_rx #(
  parameter int N  = 4,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          shift_en,
  input  logic          sin,
  input  logic          msb_first,
  output logic [N-1:0]  pout,
  output logic          pout_valid,
  input  logic          pout_ready,
  output logic          overrun,
  input  logic          clr_ovr,
  output logic          busy,
  output logic [CW-1:0] bit_cnt
);
  typedef enum logic {IDLE, RECV} state_t;
  state_t        state, state_nxt;
  logic [N-1:0]  sr, sr_nxt, pout_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          ord, ord_now, last, load, drop, pv_nxt;

  assign busy = (state == RECV);

  // next state, shift, bit counting and holding-register decisions
  always_comb begin
    ord_now   = (state == IDLE && shift_en) ? msb_first : ord;
    sr_nxt    = shift_en ? (ord_now ? {sr[N-2:0], sin} : {sin, sr[N-1:1]}) : sr;
    last      = shift_en && bit_cnt == CW'(N-1);
    cnt_nxt   = shift_en ? (last ? '0 : bit_cnt + CW'(1)) : bit_cnt;
    state_nxt = state;
    if (state == IDLE && shift_en) state_nxt = RECV;
    else if (last) state_nxt = IDLE;
    load      = last && (!pout_valid || pout_ready);
    drop      = last && pout_valid && !pout_ready;
    pout_nxt  = load ? sr_nxt : pout;
    pv_nxt    = load | (pout_valid & ~pout_ready);
  end

  // state registers; reset drops any partial or held word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      ord        <= 1'b1;
      pout       <= '0;
      pout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= sr_nxt;
      bit_cnt    <= cnt_nxt;
      ord        <= ord_now;
      pout       <= pout_nxt;
      pout_valid <= pv_nxt;
      overrun    <= drop | (overrun & ~clr_ovr);
    end
  end
endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb_sipo_frame_rx: table-driven and scoreboard checks of sipo_frame_rx with N=4
module tb_sipo_frame_rx;
  logic       clk = 0, rst_n = 1, shift_en = 0, sin = 0, msb_first = 1, pout_ready = 1, clr_ovr = 0;
  logic [3:0] pout;
  logic       pout_valid, overrun, busy;
  logic [1:0] bit_cnt;
  int         checks = 0, errors = 0, beats = 0;
  logic [3:0] sb[$];
  typedef struct {logic [3:0] bits; logic msb; logic [3:0] exp;} vec_t;
  vec_t tbl[6];

  sipo_frame_rx #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .sin(sin), .msb_first(msb_first),
    .pout(pout), .pout_valid(pout_valid), .pout_ready(pout_ready), .overrun(overrun),
    .clr_ovr(clr_ovr), .busy(busy), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(logic b);
    sin = b;
    shift_en = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    shift_en = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [3:0] bits);
    for (int i = 3; i >= 0; i--) strobe(bits[i]);
    shift_en = 0;
  endtask

  always @(negedge clk)
    if (rst_n && pout_valid && pout_ready) begin
      beats++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h, expected no word", pout);
      end else chk("sb_order", pout, sb.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b1011, 1'b1, 4'b1011};
    tbl[1] = '{4'b1011, 1'b0, 4'b1101};
    tbl[2] = '{4'b0001, 1'b1, 4'b0001};
    tbl[3] = '{4'b0001, 1'b0, 4'b1000};
    tbl[4] = '{4'b1100, 1'b0, 4'b0011};
    tbl[5] = '{4'b0110, 1'b1, 4'b0110};
    #1 rst_n = 0;
    #1;
    chk("rst_pout", pout, 0);
    chk("rst_valid", pout_valid, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", bit_cnt, 0);
    #9 rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      msb_first = tbl[i].msb;
      sb.push_back(tbl[i].exp);
      send(tbl[i].bits);
      chk("tbl_pout", pout, tbl[i].exp);
      chk("tbl_valid", pout_valid, 1);
      idle(1);
      chk("tbl_valid_drop", pout_valid, 0);
    end
    msb_first = 1;
    sb.push_back(4'b1011);
    for (int i = 0; i < 4; i++) begin
      strobe(i == 1 ? 1'b0 : 1'b1);
      chk("s2_busy", busy, i < 3);
      chk("s2_cnt", bit_cnt, (i + 1) % 4);
      chk("s2_valid", pout_valid, i == 3);
    end
    shift_en = 0;
    chk("s2_pout", pout, 4'b1011);
    idle(1);
    chk("s2_valid_one", pout_valid, 0);
    msb_first = 0;
    sb.push_back(4'b1101);
    strobe(1);
    chk("s3_cnt1", bit_cnt, 1);
    strobe(0);
    chk("s3_cnt2", bit_cnt, 2);
    msb_first = 1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("s3_gap_cnt", bit_cnt, 2);
      chk("s3_gap_busy", busy, 1);
    end
    strobe(1);
    chk("s3_cnt3", bit_cnt, 3);
    idle(1);
    chk("s3_gap2_cnt", bit_cnt, 3);
    strobe(1);
    shift_en = 0;
    chk("s3_cnt0", bit_cnt, 0);
    chk("s3_pout", pout, 4'b1101);
    chk("s3_valid", pout_valid, 1);
    idle(1);
    pout_ready = 0;
    send(4'hA);
    chk("s4_pout_a", pout, 4'hA);
    chk("s4_ovr0", overrun, 0);
    send(4'h5);
    chk("s4_pout_hold", pout, 4'hA);
    chk("s4_ovr1", overrun, 1);
    chk("s4_valid", pout_valid, 1);
    clr_ovr = 1;
    idle(1);
    clr_ovr = 0;
    chk("s4_ovr_clr", overrun, 0);
    chk("s4_pout_after_clr", pout, 4'hA);
    sb.push_back(4'hA);
    pout_ready = 1;
    idle(1);
    chk("s4_drained", pout_valid, 0);
    pout_ready = 0;
    send(4'h3);
    chk("s5_pout3", pout, 4'h3);
    sb.push_back(4'h3);
    sb.push_back(4'hC);
    strobe(1);
    strobe(1);
    strobe(0);
    pout_ready = 1;
    strobe(0);
    shift_en = 0;
    chk("s5_pout_c", pout, 4'hC);
    chk("s5_valid", pout_valid, 1);
    chk("s5_ovr", overrun, 0);
    idle(1);
    chk("s5_valid_drop", pout_valid, 0);
    beats = 0;
    for (int w = 0; w < 8; w++) begin
      logic [3:0] wv;
      wv = 4'(w);
      sb.push_back(wv);
      for (int i = 3; i >= 0; i--) begin
        strobe(wv[i]);
        chk("s6_valid_beat", pout_valid, i == 0);
      end
      chk("s6_pout", pout, wv);
    end
    idle(1);
    chk("s6_beats", beats, 8);
    chk("s6_ovr", overrun, 0);
    chk("sb_empty", sb.size(), 0);
    pout_ready = 0;
    send(4'h9);
    strobe(1);
    strobe(0);
    shift_en = 0;
    chk("s1_pre_busy", busy, 1);
    chk("s1_pre_cnt", bit_cnt, 2);
    chk("s1_pre_valid", pout_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("s1_pout", pout, 0);
    chk("s1_valid", pout_valid, 0);
    chk("s1_ovr", overrun, 0);
    chk("s1_busy", busy, 0);
    chk("s1_cnt", bit_cnt, 0);
    rst_n = 1;
    chk("sb_final_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
